// File: rtl/lab3ca_toplevel.sv
// 32 x 32-bit register file: two combinational read ports (A, B), one clocked
// write port (C). Every entry, including 0, is an ordinary writable register.
module lab3ca_toplevel #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] Dc,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Da,
  output logic [DATA_WIDTH-1:0] Db
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  // Reset outranks a write presented in the same cycle.
  always_comb begin
    regs_d = regs_q;
    if (reset)
      regs_d = '0;
    else if (write)
      regs_d[rd] = Dc;
  end

  always_ff @(posedge clk)
    regs_q <= regs_d;

  // Reads come straight from storage: no bypass of the in-flight write.
  assign Da = regs_q[rs1];
  assign Db = regs_q[rs2];

endmodule

// File: tb/tb_lab3ca_toplevel.sv
// Directed walk through the register-file behaviour followed by random traffic
// checked against an array model of the 32 registers.
module tb_lab3ca_toplevel;
  logic        clk = 1'b0;
  logic        reset, write;
  logic [31:0] Dc, Da, Db;
  logic [4:0]  rs1, rs2, rd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [32];
  bit          known [32];

  lab3ca_toplevel dut (
    .Dc(Dc), .write(write), .rs1(rs1), .rs2(rs2), .rd(rd),
    .clk(clk), .reset(reset), .Da(Da), .Db(Db)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample the inputs the edge will see, advance one edge, update the model.
  task automatic tick();
    bit          r, w;
    logic [4:0]  a;
    logic [31:0] d;
    r = reset; w = write; a = rd; d = Dc;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin mdl[i] = '0; known[i] = 1'b1; end
    end else if (w) begin
      mdl[a] = d; known[a] = 1'b1;
    end
    #1;
  endtask

  task automatic chk_ports(input string tag);
    #1;
    if (known[rs1]) chk({tag, "_Da"}, Da, mdl[rs1]);
    if (known[rs2]) chk({tag, "_Db"}, Db, mdl[rs2]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) known[i] = 1'b0;

    // Write then read entry 0.
    reset = 0; write = 1; rs1 = 0; rs2 = 1; rd = 0; Dc = 32'd73;
    tick();
    chk("wr0_Da", Da, 32'd73);

    // Second entry.
    rd = 1; Dc = 32'd88;
    tick();
    chk("wr1_Db", Db, 32'd88);
    chk("wr1_Da_hold", Da, 32'd73);

    // Reset wins over a simultaneous write.
    rd = 0; Dc = 32'd42; reset = 1;
    #1;
    chk("rst_pre_Da", Da, 32'd73);
    chk("rst_pre_Db", Db, 32'd88);
    tick();
    chk("rst_Da", Da, 32'd0);
    chk("rst_Db", Db, 32'd0);

    // Post-reset writes, then combinational read-address change.
    reset = 0; rd = 3; Dc = 32'd10;
    tick();
    rd = 2; Dc = 32'd967;
    tick();
    write = 0; rs1 = 2; rs2 = 3;
    #1;
    chk("comb_Da", Da, 32'd967);
    chk("comb_Db", Db, 32'd10);

    // Write disabled.
    rd = 2; Dc = 32'd5;
    tick();
    chk("wdis_Da", Da, 32'd967);

    // Read-during-write: old value before the edge, new after.
    write = 1; rs1 = 7; rd = 7; Dc = 32'hDEADBEEF;
    #1;
    chk("rdw_pre", Da, 32'd0);
    tick();
    chk("rdw_post", Da, 32'hDEADBEEF);

    // Full sweep on both ports.
    for (int i = 0; i < 32; i++) begin
      rd = 5'(i); Dc = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
      tick();
    end
    write = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_Da%0d", i), Da, 32'hA500_0000 + 32'(i) * 32'h0001_0203);
      chk($sformatf("sweep_Db%0d", 31 - i), Db, 32'hA500_0000 + 32'(31 - i) * 32'h0001_0203);
    end

    // Reset clears everything.
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      chk($sformatf("clr_Da%0d", i), Da, 32'd0);
      chk($sformatf("clr_Db%0d", i), Db, 32'd0);
    end

    // Random traffic against the model, checking both before and after each edge.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 19) == 0);
      write = $urandom_range(0, 1);
      rd    = 5'($urandom_range(0, 31));
      rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2   = 5'($urandom_range(0, 31));
      Dc    = $urandom;
      chk_ports($sformatf("rnd_pre%0d", n));
      tick();
      chk_ports($sformatf("rnd_post%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
